// File: rtl/fft_stream_host.sv
// rtl/fft_stream_host.sv - frame-buffered radix-2 butterfly engine with stream in/out and LFSR payload
// Samples are loaded into a local frame, transformed in place one butterfly per cycle, then streamed out.
module fft_stream_host #(
    parameter int          N_POINTS   = 8,
    parameter int          DATA_WIDTH = 16,
    parameter logic [39:0] GEN_SEED   = 40'h123456789A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_real,
    input  logic [DATA_WIDTH-1:0] in_imag,
    input  logic [1:0]            mode,
    input  logic                  mix_en,
    input  logic [DATA_WIDTH-1:0] mix_word,
    output logic [39:0]           gen_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_real,
    output logic [DATA_WIDTH-1:0] out_imag,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overflow
);
    localparam int LOG2 = $clog2(N_POINTS);
    localparam int SW   = (LOG2 > 1) ? $clog2(LOG2) : 1;
    localparam int KW   = LOG2 - 1;
    localparam logic [39:0]     SEED       = (GEN_SEED == 40'd0) ? 40'd1 : GEN_SEED;
    localparam logic [SW-1:0]   LAST_STAGE = SW'(LOG2 - 1);
    localparam logic [KW-1:0]   LAST_K     = {KW{1'b1}};
    localparam logic [LOG2-1:0] LAST_IDX   = {LOG2{1'b1}};

    typedef enum logic [1:0] {LOAD, COMPUTE, MIX, UNLOAD} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] re_mem [N_POINTS];
    logic [DATA_WIDTH-1:0] im_mem [N_POINTS];
    logic [LOG2-1:0]       idx;
    logic [SW-1:0]         stage;
    logic [KW-1:0]         k;
    logic                  scaled;
    logic                  bypass;
    logic                  mix_lat;
    logic [39:0]           lfsr;

    logic [LOG2-1:0]       span, k_ext, bf_i, bf_j;
    logic [DATA_WIDTH-1:0] a_re, b_re, a_im, b_im;
    logic [DATA_WIDTH:0]   s_re, d_re, s_im, d_im;
    logic                  bf_ovf;

    function automatic logic [DATA_WIDTH-1:0] trim(input logic [DATA_WIDTH:0] v, input logic sc);
        return sc ? v[DATA_WIDTH:1] : v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic wide_ovf(input logic [DATA_WIDTH:0] v);
        return v[DATA_WIDTH] ^ v[DATA_WIDTH-1];
    endfunction

    // Butterfly k of a stage: insert a zero at bit 'stage' of k to get the lower index.
    always_comb begin
        span   = LOG2'(1) << stage;
        k_ext  = LOG2'(k);
        bf_i   = (((k_ext >> stage) << stage) << 1) | (k_ext & (span - LOG2'(1)));
        bf_j   = bf_i | span;
        a_re   = re_mem[bf_i];
        b_re   = re_mem[bf_j];
        a_im   = im_mem[bf_i];
        b_im   = im_mem[bf_j];
        s_re   = {a_re[DATA_WIDTH-1], a_re} + {b_re[DATA_WIDTH-1], b_re};
        d_re   = {a_re[DATA_WIDTH-1], a_re} - {b_re[DATA_WIDTH-1], b_re};
        s_im   = {a_im[DATA_WIDTH-1], a_im} + {b_im[DATA_WIDTH-1], b_im};
        d_im   = {a_im[DATA_WIDTH-1], a_im} - {b_im[DATA_WIDTH-1], b_im};
        bf_ovf = !scaled && (wide_ovf(s_re) || wide_ovf(d_re) || wide_ovf(s_im) || wide_ovf(d_im));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            idx      <= '0;
            stage    <= '0;
            k        <= '0;
            scaled   <= 1'b0;
            bypass   <= 1'b0;
            mix_lat  <= 1'b0;
            overflow <= 1'b0;
            lfsr     <= SEED;
            for (int n = 0; n < N_POINTS; n++) begin
                re_mem[n] <= '0;
                im_mem[n] <= '0;
            end
        end else begin
            // The payload generator idles only while waiting for input.
            if (state != LOAD || in_valid)
                lfsr <= {lfsr[38:0], lfsr[39] ^ lfsr[37] ^ lfsr[20] ^ lfsr[18]};
            case (state)
                LOAD: if (in_valid) begin
                    re_mem[idx] <= in_real;
                    im_mem[idx] <= in_imag;
                    idx         <= idx + 1'b1;
                    if (idx == '0) begin
                        scaled   <= (mode == 2'd1);
                        bypass   <= (mode == 2'd2);
                        mix_lat  <= mix_en;
                        overflow <= 1'b0;
                    end
                    if (idx == LAST_IDX) begin
                        stage <= '0;
                        k     <= '0;
                        if (bypass) state <= mix_lat ? MIX : UNLOAD;
                        else        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    re_mem[bf_i] <= trim(s_re, scaled);
                    re_mem[bf_j] <= trim(d_re, scaled);
                    im_mem[bf_i] <= trim(s_im, scaled);
                    im_mem[bf_j] <= trim(d_im, scaled);
                    overflow     <= overflow | bf_ovf;
                    k            <= k + 1'b1;
                    if (k == LAST_K) begin
                        if (stage == LAST_STAGE) begin
                            stage <= '0;
                            state <= mix_lat ? MIX : UNLOAD;
                        end else begin
                            stage <= stage + 1'b1;
                        end
                    end
                end
                MIX: begin
                    for (int n = 0; n < N_POINTS; n++)
                        re_mem[n] <= re_mem[n] ^ mix_word;
                    state <= UNLOAD;
                end
                UNLOAD: if (out_ready) begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == UNLOAD);
    assign busy      = (state == COMPUTE) || (state == MIX);
    assign out_last  = (state == UNLOAD) && (idx == LAST_IDX);
    assign out_real  = (state == UNLOAD) ? re_mem[idx] : '0;
    assign out_imag  = (state == UNLOAD) ? im_mem[idx] : '0;
    assign gen_word  = lfsr;

endmodule

// File: tb/tb_fft_stream_host.sv
// tb/tb_fft_stream_host.sv - randomized frames checked against a behavioural butterfly model
`timescale 1ns/1ps
module tb_fft_stream_host;
    localparam int          N    = 8;
    localparam int          DW   = 16;
    localparam int          LOG2 = 3;
    localparam logic [39:0] SEED = 40'h123456789A;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, mix_en, out_valid, out_ready, out_last, busy, overflow;
    logic [DW-1:0] in_real, in_imag, mix_word, out_real, out_imag;
    logic [1:0]    mode;
    logic [39:0]   gen_word;

    fft_stream_host #(.N_POINTS(N), .DATA_WIDTH(DW), .GEN_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .mode(mode), .mix_en(mix_en),
        .mix_word(mix_word), .gen_word(gen_word), .out_valid(out_valid),
        .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_last(out_last), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef enum {P_LOAD, P_BUSY, P_UNLOAD} phase_t;
    phase_t        m_phase;
    int            m_idx, m_busy_left;
    logic [39:0]   m_lfsr;
    logic          m_ovf, m_scaled, m_bypass, m_mix;
    logic [DW-1:0] exp_re [N];
    logic [DW-1:0] exp_im [N];
    logic [DW-1:0] got_re [N];
    logic [DW-1:0] got_im [N];
    int            frames_done = 0, handshakes = 0, busy_cnt = 0, last_busy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] fit(input int v);
        int r;
        if (m_scaled) begin
            r = (v >= 0) ? v / 2 : -((1 - v) / 2);
        end else begin
            r = v;
            if (r > 32767 || r < -32768) m_ovf = 1'b1;
        end
        while (r > 32767)  r -= 65536;
        while (r < -32768) r += 65536;
        return DW'(r);
    endfunction

    task automatic model_compute();
        int j, ar, br, ai, bi;
        for (int s = 0; s < LOG2; s++) begin
            for (int i = 0; i < N; i++) begin
                if (((i >> s) & 1) == 0) begin
                    j  = i + (1 << s);
                    ar = int'($signed(exp_re[i]));
                    br = int'($signed(exp_re[j]));
                    ai = int'($signed(exp_im[i]));
                    bi = int'($signed(exp_im[j]));
                    exp_re[i] = fit(ar + br);
                    exp_re[j] = fit(ar - br);
                    exp_im[i] = fit(ai + bi);
                    exp_im[j] = fit(ai - bi);
                end
            end
        end
    endtask

    // Single compare process: check outputs against the model, then step the model over the next edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_overflow", overflow, 0);
            check("rst_out_last", out_last, 0);
            check("rst_out_real", out_real, 0);
            check("rst_gen_word", gen_word, SEED);
            m_phase = P_LOAD;
            m_idx   = 0;
            m_lfsr  = SEED;
            m_ovf   = 1'b0;
        end else begin
            check("in_ready", in_ready, m_phase == P_LOAD);
            check("out_valid", out_valid, m_phase == P_UNLOAD);
            check("busy", busy, m_phase == P_BUSY);
            check("gen_word", gen_word, m_lfsr);
            if (m_phase != P_BUSY) check("overflow", overflow, m_ovf);
            if (m_phase == P_UNLOAD) begin
                check("out_real", out_real, exp_re[m_idx]);
                check("out_imag", out_imag, exp_im[m_idx]);
                check("out_last", out_last, m_idx == N - 1);
            end else begin
                check("out_last_idle", out_last, 0);
            end

            if (!(m_phase == P_LOAD && !in_valid))
                m_lfsr = {m_lfsr[38:0], m_lfsr[39] ^ m_lfsr[37] ^ m_lfsr[20] ^ m_lfsr[18]};
            if (busy) busy_cnt++;
            case (m_phase)
                P_LOAD: if (in_valid) begin
                    exp_re[m_idx] = in_real;
                    exp_im[m_idx] = in_imag;
                    if (m_idx == 0) begin
                        m_scaled = (mode == 2'd1);
                        m_bypass = (mode == 2'd2);
                        m_mix    = mix_en;
                        m_ovf    = 1'b0;
                        busy_cnt = 0;
                    end
                    m_idx++;
                    if (m_idx == N) begin
                        m_idx = 0;
                        if (!m_bypass) model_compute();
                        m_busy_left = (m_bypass ? 0 : LOG2 * N / 2) + (m_mix ? 1 : 0);
                        m_phase = (m_busy_left > 0) ? P_BUSY : P_UNLOAD;
                    end
                end
                P_BUSY: begin
                    if (m_busy_left == 1 && m_mix)
                        for (int i = 0; i < N; i++) exp_re[i] = exp_re[i] ^ mix_word;
                    m_busy_left--;
                    if (m_busy_left == 0) m_phase = P_UNLOAD;
                end
                P_UNLOAD: if (out_ready) begin
                    got_re[m_idx] = out_real;
                    got_im[m_idx] = out_imag;
                    handshakes++;
                    m_idx++;
                    if (m_idx == N) begin
                        m_idx   = 0;
                        m_phase = P_LOAD;
                        last_busy = busy_cnt;
                        frames_done++;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [DW-1:0] drv_re [N];
    logic [DW-1:0] drv_im [N];
    logic          rand_ready = 1'b0;
    logic          hold_mix   = 1'b0;
    logic [DW-1:0] mixw_fixed = '0;
    int            stall_at   = -1;
    int            stall_len  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid  = 1'b0;
        in_real   = DW'($urandom);
        in_imag   = DW'($urandom);
        mode      = 2'($urandom);
        mix_en    = 1'($urandom);
        mix_word  = hold_mix ? mixw_fixed : DW'($urandom);
        out_ready = rand_ready ? 1'($urandom) : 1'b1;
        if (m_phase == P_UNLOAD && m_idx == stall_at && stall_len > 0) begin
            out_ready = 1'b0;
            stall_len--;
        end
    endtask

    task automatic run_frame(input logic [1:0] m, input logic mx, input logic gaps);
        int target, n;
        target = frames_done + 1;
        for (int i = 0; i < N; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin drive_idle(); tick(); end
            drive_idle();
            in_valid = 1'b1;
            in_real  = drv_re[i];
            in_imag  = drv_im[i];
            if (i == 0) begin mode = m; mix_en = mx; end
            tick();
        end
        n = 0;
        while (frames_done < target && n < 400) begin drive_idle(); tick(); n++; end
        check("frame_complete", frames_done >= target, 1);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("seed_after_reset", gen_word, 40'h123456789A);
        tick();

        for (int i = 0; i < N; i++) begin drv_re[i] = 16'd1; drv_im[i] = 16'd0; end
        run_frame(2'd0, 1'b0, 1'b0);
        check("ones_re0", got_re[0], 16'd8);
        for (int i = 1; i < N; i++) check("ones_re_rest", got_re[i], 16'd0);
        for (int i = 0; i < N; i++) check("ones_im", got_im[i], 16'd0);
        check("ones_overflow", overflow, 0);
        check("ones_busy_cycles", last_busy, 12);

        for (int i = 0; i < N; i++) drv_re[i] = 16'd16;
        run_frame(2'd1, 1'b0, 1'b1);
        check("scaled_re0", got_re[0], 16'd16);
        for (int i = 1; i < N; i++) check("scaled_re_rest", got_re[i], 16'd0);

        for (int i = 0; i < N; i++) drv_re[i] = 16'h4000;
        run_frame(2'd0, 1'b0, 1'b0);
        check("wrap_overflow", overflow, 1);
        check("wrap_re0", got_re[0], 16'h0000);

        hold_mix = 1'b1;
        mixw_fixed = 16'h00FF;
        for (int i = 0; i < N; i++) begin drv_re[i] = DW'(i); drv_im[i] = DW'($urandom); end
        run_frame(2'd2, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) begin
            check("mix_re", got_re[i], 16'h00FF ^ DW'(i));
            check("mix_im", got_im[i], drv_im[i]);
        end
        check("mix_busy_cycles", last_busy, 1);
        hold_mix = 1'b0;

        for (int i = 0; i < N; i++) begin drv_re[i] = DW'($urandom_range(0, 255)); drv_im[i] = DW'($urandom_range(0, 255)); end
        stall_at = 3;
        stall_len = 5;
        run_frame(2'd0, 1'b0, 1'b0);
        check("stall_consumed", stall_len, 0);
        stall_at = -1;

        begin
            int hs_before, fr_before;
            hs_before = handshakes;
            fr_before = frames_done;
            for (int i = 0; i < N; i++) drive_idle();
            for (int i = 0; i < N; i++) begin
                drive_idle();
                in_valid = 1'b1;
                in_real = DW'($urandom);
                in_imag = DW'($urandom);
                if (i == 0) begin mode = 2'd0; mix_en = 1'b0; end
                tick();
            end
            repeat (5) begin drive_idle(); tick(); end
            check("busy_before_reset", busy, 1);
            rst = 1'b1;
            repeat (2) tick();
            rst = 1'b0;
            @(negedge clk);
            check("post_reset_in_ready", in_ready, 1);
            check("post_reset_out_valid", out_valid, 0);
            check("post_reset_seed", gen_word, 40'h123456789A);
            tick();
            check("no_partial_output", handshakes, hs_before);
            check("no_partial_frame", frames_done, fr_before);
        end
        for (int i = 0; i < N; i++) begin drv_re[i] = DW'($urandom); drv_im[i] = DW'($urandom); end
        run_frame(2'd0, 1'b0, 1'b1);

        for (int i = 0; i < N; i++) begin drv_re[i] = (i == 0) ? 16'd5 : 16'd0; drv_im[i] = 16'd0; end
        run_frame(2'd0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) check("impulse_re", got_re[i], 16'd5);

        rand_ready = 1'b1;
        for (int f = 0; f < 14; f++) begin
            for (int i = 0; i < N; i++) begin
                drv_re[i] = (f % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 4095));
                drv_im[i] = (f % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 4095));
            end
            run_frame(2'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
